alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-driven front end for the 32-bit 74381-style ALU. Accepts operation commands over a valid/ready handshake and registers the operands, select and carry onto the ALU inputs. After a programmable settle time it captures F/Cout/overflow into a result register and presents the result downstream with backpressure. A chain mode feeds the previous result back as operand A, so multi-step arithmetic runs without re-sending intermediate values.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU.
- `SETTLE_CYCLES`, 1, clock cycles the ALU inputs are held before capture; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command this cycle.
- `cmd_a`  in  WIDTH  operand A; ignored when `cmd_chain`=1.
- `cmd_b`  in  WIDTH  operand B.
- `cmd_s`  in  3  ALU function select, passed through unchanged.
- `cmd_cin`  in  1  carry-in.
- `cmd_chain`  in  1  use the last captured `res_f` as A.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands.
- `alu_s`  out  3  registered select.
- `alu_cin`  out  1  registered carry-in.
- `alu_f`  in  WIDTH  ALU result.
- `alu_cout`  in  1  ALU carry-out.
- `alu_ovf`  in  1  ALU overflow.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream takes the result.
- `res_f`  out  WIDTH  captured result.
- `res_cout`  out  1  captured carry-out.
- `res_ovf`  out  1  captured overflow.
- `ovf_sticky`  out  1  OR of `res_ovf` across the current chain.
- `busy`  out  1  high in the SETTLE or RESULT state.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On handshake, load the `alu_*` registers, load `cnt`=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: if `cnt`==0, capture `alu_f`/`alu_cout`/`alu_ovf` into the `res_*` registers, set `res_valid`, go to RESULT. Otherwise decrement `cnt`.
  - RESULT: hold all `res_*` outputs stable while `res_ready`=0. On `res_ready`=1, clear `res_valid` and go to IDLE, unless a command is accepted on the same edge (see handoff below).
- `cmd_ready` = (state==IDLE) || (state==RESULT && res_ready).
- Same-edge handoff: in RESULT, when both `res_ready` and `cmd_valid` are 1, the result retires and the new command loads on the same edge. Next state is SETTLE.
- Chain operand: `alu_a` loads the current `res_f` register. This still applies during same-edge handoff: the value being retired is the one used. After reset, `res_f`=0, so chain operand A is 0.
- `ovf_sticky`:
  - Cleared when a command with `cmd_chain`=0 is accepted.
  - ORed with `alu_ovf` on each capture.
  - Readable in any state.
- No arithmetic inside the block. Operands are passed through bit-exact at WIDTH bits. `cmd_s` encoding belongs to the ALU.
- Commands offered in SETTLE, or in RESULT with `res_ready`=0, are not accepted (`cmd_ready`=0). The source must hold `cmd_valid` and its data.

## Timing
- Reset values: state IDLE, and every output except `cmd_ready` is 0: `alu_a`, `alu_b`, `alu_s`, `alu_cin`, `res_f`, `res_cout`, `res_ovf`, `res_valid`, `ovf_sticky`, `busy`. `cmd_ready`=1.
- Reset asserted mid-operation aborts immediately: any pending result is discarded, no partial handshake.
- Latency: command accepted at edge T → `alu_*` valid after T → capture at edge T+SETTLE_CYCLES → `res_valid` high after that edge.
- Throughput:
  - With `res_ready` tied to 1: one command per SETTLE_CYCLES+1 cycles.
  - With back-to-back handoff: `cmd_ready` drops for exactly SETTLE_CYCLES cycles per command.
- `alu_*` outputs change only on an accepting edge. They hold their value through SETTLE and RESULT.
- `res_*` outputs change only on a capture edge.

## Structure
- Shared package `alu_pkg` holds:
  - `WIDTH_DEFAULT`.
  - Select localparams `OP_CLR`=000, `OP_BMA`=001, `OP_AMB`=010, `OP_ADD`=011, `OP_XOR`=100, `OP_OR`=101, `OP_AND`=110, `OP_PRE`=111.
  - State encoding for IDLE/SETTLE/RESULT.
- No sub-module. The ALU (`system`) is instantiated beside this block at the level above, not inside it.

## Test plan
- Single add: `cmd_a`=20, `cmd_b`=19, `cmd_s`=011, `cmd_cin`=0, `res_ready`=1 → `res_f`=39, `res_cout`=0, `res_ovf`=0. `res_valid` rises 1 edge after the accepting edge (SETTLE_CYCLES=1).
- Chain: add 20+19, then a chain command with `cmd_b`=1, `cmd_s`=010, and a garbage `cmd_a` → `alu_a`=39, `res_f`=38.
- Backpressure: hold `res_ready`=0 for 5 cycles after the result → `res_f`/`res_valid` stable, `cmd_ready`=0 throughout, and a held command is accepted on the `res_ready` edge.
- Overflow sticky: `cmd_a`=0x7FFFFFFF, `cmd_b`=1, `cmd_s`=011 → `res_ovf`=1, `ovf_sticky`=1. A chained command without overflow keeps sticky at 1. The next non-chain command clears it.
- Settle latency: SETTLE_CYCLES=3, `cmd_a`=16, `cmd_b`=8, `cmd_s`=010 → `res_f`=8, captured exactly 3 edges after accept. `cmd_ready`=0 for 3 cycles.
- Reset mid-op: assert `rst` during SETTLE → all outputs 0 and `cmd_ready`=1 asynchronously. The next command executes normally, and chain A=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 74381-style ALU and its command sequencer.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  // ALU function select codes; the sequencer passes these through untouched.
  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_BMA = 3'b001;
  localparam logic [2:0] OP_AMB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_PRE = 3'b111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResult = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the ALU: registers operands onto the ALU inputs, waits a
// programmable settle time, captures the result and hands it downstream.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_s,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             ovf_sticky,
  output logic             busy
);

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_s_q, alu_s_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] res_f_q, res_f_d;
  logic             res_cout_q, res_cout_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             sticky_q, sticky_d;
  logic             accept;

  // Handshake: accept when idle, or when the held result retires this edge.
  always_comb begin
    cmd_ready = (state_q == StIdle) || ((state_q == StResult) && res_ready);
    accept    = cmd_valid && cmd_ready;
  end

  // Next-state logic: FSM sequencing, capture, and command load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_cin_d   = alu_cin_q;
    res_f_d     = res_f_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    sticky_d    = sticky_q;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          res_f_d     = alu_f;
          res_cout_d  = alu_cout;
          res_ovf_d   = alu_ovf;
          res_valid_d = 1'b1;
          sticky_d    = sticky_q | alu_ovf;
          state_d     = StResult;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = accept ? StSettle : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Chain uses the result register as it stands, i.e. the value retiring now.
    if (accept) begin
      alu_a_d   = cmd_chain ? res_f_q : cmd_a;
      alu_b_d   = cmd_b;
      alu_s_d   = cmd_s;
      alu_cin_d = cmd_cin;
      cnt_d     = CntInit;
      if (!cmd_chain) sticky_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= 3'd0;
      alu_cin_q   <= 1'b0;
      res_f_q     <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_cin_q   <= alu_cin_d;
      res_f_q     <= res_f_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign alu_cin    = alu_cin_q;
  assign res_f      = res_f_q;
  assign res_cout   = res_cout_q;
  assign res_ovf    = res_ovf_q;
  assign res_valid  = res_valid_q;
  assign ovf_sticky = sticky_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench: two sequencers (settle 1 and 3) each driving a behavioural ALU, checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_alu_cmd_sequencer;

  localparam int W = 32;

  logic         clk, rst;
  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [W-1:0] cmd_a     [2];
  logic [W-1:0] cmd_b     [2];
  logic [2:0]   cmd_s     [2];
  logic         cmd_cin   [2];
  logic         cmd_chain [2];
  logic [W-1:0] alu_a     [2];
  logic [W-1:0] alu_b     [2];
  logic [2:0]   alu_s     [2];
  logic         alu_cin   [2];
  logic [W-1:0] alu_f     [2];
  logic         alu_cout  [2];
  logic         alu_ovf   [2];
  logic         res_valid [2];
  logic         res_ready [2];
  logic [W-1:0] res_f     [2];
  logic         res_cout  [2];
  logic         res_ovf   [2];
  logic         ovf_sticky[2];
  logic         busy      [2];

  int total = 0;
  int bad   = 0;

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .cmd_s(cmd_s[0]), .cmd_cin(cmd_cin[0]), .cmd_chain(cmd_chain[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]), .alu_cin(alu_cin[0]),
    .alu_f(alu_f[0]), .alu_cout(alu_cout[0]), .alu_ovf(alu_ovf[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_f(res_f[0]),
    .res_cout(res_cout[0]), .res_ovf(res_ovf[0]), .ovf_sticky(ovf_sticky[0]), .busy(busy[0])
  );

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .cmd_s(cmd_s[1]), .cmd_cin(cmd_cin[1]), .cmd_chain(cmd_chain[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]), .alu_cin(alu_cin[1]),
    .alu_f(alu_f[1]), .alu_cout(alu_cout[1]), .alu_ovf(alu_ovf[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_f(res_f[1]),
    .res_cout(res_cout[1]), .res_ovf(res_ovf[1]), .ovf_sticky(ovf_sticky[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // 74381-style ALU: returns {ovf, cout, f}. Subtractions are x + ~y + cin.
  function automatic logic [33:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] s, input logic cin);
    logic [31:0] x, y;
    logic [32:0] sum;
    x = a;
    y = b;
    case (s)
      3'b000: return 34'd0;
      3'b001: x = ~a;
      3'b010: y = ~b;
      3'b011: ;
      3'b100: return {2'b00, a ^ b};
      3'b101: return {2'b00, a | b};
      3'b110: return {2'b00, a & b};
      default: return {2'b00, 32'hFFFF_FFFF};
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    return {(x[31] == y[31]) && (sum[31] != x[31]), sum[32], sum[31:0]};
  endfunction

  // Environment ALUs fed by the DUT outputs.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      alu_f[i]    = alu_calc(alu_a[i], alu_b[i], alu_s[i], alu_cin[i]) >> 0;
      alu_cout[i] = alu_calc(alu_a[i], alu_b[i], alu_s[i], alu_cin[i]) >> 32 & 34'd1;
      alu_ovf[i]  = alu_calc(alu_a[i], alu_b[i], alu_s[i], alu_cin[i]) >> 33 & 34'd1;
    end
  end

  // Transaction-level model: an operation is "in flight" from accept until the
  // result retires; its result appears SETTLE_CYCLES edges after accept.
  logic         m_inop  [2];
  logic         m_valid [2];
  logic         m_acc   [2];
  int           m_age   [2];
  logic [W-1:0] m_a     [2];
  logic [W-1:0] m_b     [2];
  logic [2:0]   m_s     [2];
  logic         m_cin   [2];
  logic [W-1:0] m_f     [2];
  logic         m_cout  [2];
  logic         m_ovf   [2];
  logic         m_sticky[2];
  logic         t_rdy, t_acc;
  logic [33:0]  t_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_inop[i] <= 0; m_valid[i] <= 0; m_acc[i] <= 0; m_age[i] <= 0;
        m_a[i] <= 0; m_b[i] <= 0; m_s[i] <= 0; m_cin[i] <= 0;
        m_f[i] <= 0; m_cout[i] <= 0; m_ovf[i] <= 0; m_sticky[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_rdy = !m_inop[i] || (m_valid[i] && res_ready[i]);
        t_acc = cmd_valid[i] && t_rdy;
        m_acc[i] <= t_acc;
        if (m_inop[i] && !m_valid[i]) begin
          if (m_age[i] + 1 == sc_of(i)) begin
            t_r = alu_calc(m_a[i], m_b[i], m_s[i], m_cin[i]);
            m_f[i]      <= t_r[31:0];
            m_cout[i]   <= t_r[32];
            m_ovf[i]    <= t_r[33];
            m_sticky[i] <= m_sticky[i] | t_r[33];
            m_valid[i]  <= 1'b1;
          end else begin
            m_age[i] <= m_age[i] + 1;
          end
        end
        if (m_valid[i] && res_ready[i]) begin
          m_valid[i] <= 1'b0;
          m_inop[i]  <= 1'b0;
        end
        if (t_acc) begin
          m_a[i]     <= cmd_chain[i] ? m_f[i] : cmd_a[i];
          m_b[i]     <= cmd_b[i];
          m_s[i]     <= cmd_s[i];
          m_cin[i]   <= cmd_cin[i];
          m_inop[i]  <= 1'b1;
          m_valid[i] <= 1'b0;
          m_age[i]   <= 0;
          if (!cmd_chain[i]) m_sticky[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("cmd_ready", i, 64'(cmd_ready[i]),
            64'(!m_inop[i] || (m_valid[i] && res_ready[i])));
        chk("alu_a", i, 64'(alu_a[i]), 64'(m_a[i]));
        chk("alu_b", i, 64'(alu_b[i]), 64'(m_b[i]));
        chk("alu_s", i, 64'(alu_s[i]), 64'(m_s[i]));
        chk("alu_cin", i, 64'(alu_cin[i]), 64'(m_cin[i]));
        chk("res_valid", i, 64'(res_valid[i]), 64'(m_valid[i]));
        chk("res_f", i, 64'(res_f[i]), 64'(m_f[i]));
        chk("res_cout", i, 64'(res_cout[i]), 64'(m_cout[i]));
        chk("res_ovf", i, 64'(res_ovf[i]), 64'(m_ovf[i]));
        chk("ovf_sticky", i, 64'(ovf_sticky[i]), 64'(m_sticky[i]));
        chk("busy", i, 64'(busy[i]), 64'(m_inop[i]));
      end
    end
  end

  // Offer a command and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s, input logic cin, input logic chain);
    bit done = 0;
    cmd_a[i] = a; cmd_b[i] = b; cmd_s[i] = s; cmd_cin[i] = cin; cmd_chain[i] = chain;
    cmd_valid[i] = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #1;
      if (m_acc[i]) done = 1;
    end
    if (!done) chk("accept_timeout", i, 64'd0, 64'd1);
    cmd_valid[i] = 1'b0;
  endtask

  // Wait at negedges until the DUT shows a result.
  task automatic wait_res(input int i);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (res_valid[i] === 1'b1) done = 1;
    end
    if (!done) chk("result_timeout", i, 64'd0, 64'd1);
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_cmd_ready", i, 64'(cmd_ready[i]), 64'd1);
    chk("rst_alu_a", i, 64'(alu_a[i]), 64'd0);
    chk("rst_alu_b", i, 64'(alu_b[i]), 64'd0);
    chk("rst_alu_s", i, 64'(alu_s[i]), 64'd0);
    chk("rst_alu_cin", i, 64'(alu_cin[i]), 64'd0);
    chk("rst_res_f", i, 64'(res_f[i]), 64'd0);
    chk("rst_res_cout", i, 64'(res_cout[i]), 64'd0);
    chk("rst_res_ovf", i, 64'(res_ovf[i]), 64'd0);
    chk("rst_res_valid", i, 64'(res_valid[i]), 64'd0);
    chk("rst_ovf_sticky", i, 64'(ovf_sticky[i]), 64'd0);
    chk("rst_busy", i, 64'(busy[i]), 64'd0);
  endtask

  // Random traffic: hold an unaccepted command, otherwise maybe offer a new one.
  task automatic drive(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (!(cmd_valid[i] && !m_acc[i])) begin
        cmd_valid[i] = ($urandom_range(2) != 0);
        case ($urandom_range(3))
          0: cmd_a[i] = 32'h7FFF_FFFF;
          1: cmd_a[i] = 32'h8000_0000;
          default: cmd_a[i] = $urandom;
        endcase
        cmd_b[i]     = ($urandom_range(1) == 0) ? 32'(1) : $urandom;
        cmd_s[i]     = 3'($urandom_range(7));
        cmd_cin[i]   = 1'($urandom_range(1));
        cmd_chain[i] = ($urandom_range(2) == 0);
      end
      res_ready[i] = ($urandom_range(3) != 0);
    end
    cmd_valid[i] = 1'b0;
    res_ready[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 0; cmd_a[i] = 0; cmd_b[i] = 0; cmd_s[i] = 0;
      cmd_cin[i] = 0; cmd_chain[i] = 0; res_ready[i] = 1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single add, settle 1: result visible after the edge following accept.
    send(0, 20, 19, 3'b011, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_not_yet", 0, 64'(res_valid[0]), 64'd0);
    @(negedge clk);
    chk("add_valid", 0, 64'(res_valid[0]), 64'd1);
    chk("add_f", 0, 64'(res_f[0]), 64'd39);
    chk("add_cout", 0, 64'(res_cout[0]), 64'd0);
    chk("add_ovf", 0, 64'(res_ovf[0]), 64'd0);

    // Chain: garbage A ignored, previous result 39 used as A; 39 - 1 = 38.
    repeat (2) @(posedge clk);
    #1;
    send(0, 20, 19, 3'b011, 1'b0, 1'b0);
    wait_res(0);
    send(0, 32'hDEAD_BEEF, 1, 3'b010, 1'b1, 1'b1);
    chk("chain_alu_a", 0, 64'(alu_a[0]), 64'd39);
    wait_res(0);
    chk("chain_f", 0, 64'(res_f[0]), 64'd38);

    // Backpressure: result and stall held for 5 cycles, then same-edge handoff.
    @(posedge clk);
    #1 res_ready[0] = 1'b0;
    send(0, 5, 6, 3'b011, 1'b0, 1'b0);
    wait_res(0);
    cmd_a[0] = 100; cmd_b[0] = 1; cmd_s[0] = 3'b011; cmd_cin[0] = 0; cmd_chain[0] = 0;
    cmd_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 0, 64'(res_valid[0]), 64'd1);
      chk("bp_f", 0, 64'(res_f[0]), 64'd11);
      chk("bp_ready", 0, 64'(cmd_ready[0]), 64'd0);
    end
    res_ready[0] = 1'b1;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    chk("bp_handoff_a", 0, 64'(alu_a[0]), 64'd100);
    chk("bp_handoff_valid", 0, 64'(res_valid[0]), 64'd0);
    chk("bp_handoff_busy", 0, 64'(busy[0]), 64'd1);
    wait_res(0);
    chk("bp_second_f", 0, 64'(res_f[0]), 64'd101);

    // Overflow sticky across a chain, cleared by the next plain command.
    repeat (2) @(posedge clk);
    #1;
    send(0, 32'h7FFF_FFFF, 1, 3'b011, 1'b0, 1'b0);
    wait_res(0);
    chk("ovf_f", 0, 64'(res_f[0]), 64'h8000_0000);
    chk("ovf_res", 0, 64'(res_ovf[0]), 64'd1);
    chk("ovf_sticky", 0, 64'(ovf_sticky[0]), 64'd1);
    send(0, 0, 1, 3'b011, 1'b0, 1'b1);
    wait_res(0);
    chk("ovf_chain_f", 0, 64'(res_f[0]), 64'h8000_0001);
    chk("ovf_chain_res", 0, 64'(res_ovf[0]), 64'd0);
    chk("ovf_chain_sticky", 0, 64'(ovf_sticky[0]), 64'd1);
    send(0, 1, 1, 3'b011, 1'b0, 1'b0);
    chk("ovf_cleared", 0, 64'(ovf_sticky[0]), 64'd0);

    // Settle of 3 on the second instance: 16 - 8 = 8 after exactly 3 edges.
    send(1, 16, 8, 3'b010, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("settle_ready", 1, 64'(cmd_ready[1]), 64'd0);
      chk("settle_valid", 1, 64'(res_valid[1]), 64'd0);
    end
    @(negedge clk);
    chk("settle_done", 1, 64'(res_valid[1]), 64'd1);
    chk("settle_f", 1, 64'(res_f[1]), 64'd8);

    // Reset in SETTLE clears everything at once; a following chain sees A = 0.
    repeat (2) @(posedge clk);
    #1;
    send(1, 3, 4, 3'b011, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals(1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(1, 999, 5, 3'b011, 1'b0, 1'b1);
    chk("post_rst_chain_a", 1, 64'(alu_a[1]), 64'd0);
    wait_res(1);
    chk("post_rst_f", 1, 64'(res_f[1]), 64'd5);

    // Randomized traffic on both instances concurrently.
    fork
      drive(0, 3000);
      drive(1, 3000);
    join
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
